// File: rtl/aclk_keyreg.sv
// Keypad entry stage for the alarm clock: gathers four BCD digits into an
// HH:MM buffer, validates it, and issues a one-cycle alarm/current-time load strobe.
//
// state | meaning
// IDLE  | no digits entered, buffer shows last committed/cleared value
// ENTRY | 1-3 digits entered
// FULL  | 4 or more digits entered, buffer holds the last four
module aclk_keyreg #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       one_second,
  output logic [3:0] key_buffer_ms_hr,
  output logic [3:0] key_buffer_ls_hr,
  output logic [3:0] key_buffer_ms_min,
  output logic [3:0] key_buffer_ls_min,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_new_time,
  output logic       entry_error,
  output logic       entry_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [3:0] KEY_ALARM = 4'd10;
  localparam logic [3:0] KEY_TIME  = 4'd11;
  localparam logic [3:0] KEY_CLEAR = 4'd12;
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_SEC - 1);

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] tmr, tmr_n;
  logic [3:0] ms_hr_n, ls_hr_n, ms_min_n, ls_min_n;
  logic       load_a_n, load_c_n, error_n, timeout_n;
  logic       buf_valid;

  always_comb begin
    buf_valid = ((key_buffer_ms_hr < 4'd2 && key_buffer_ls_hr <= 4'd9) ||
                 (key_buffer_ms_hr == 4'd2 && key_buffer_ls_hr <= 4'd3)) &&
                (key_buffer_ms_min <= 4'd5) && (key_buffer_ls_min <= 4'd9);
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tmr_n     = tmr;
    ms_hr_n   = key_buffer_ms_hr;
    ls_hr_n   = key_buffer_ls_hr;
    ms_min_n  = key_buffer_ms_min;
    ls_min_n  = key_buffer_ls_min;
    load_a_n  = 1'b0;
    load_c_n  = 1'b0;
    error_n   = 1'b0;
    timeout_n = 1'b0;

    // Keys 13-15 fall through to the tick branch as if no key was pressed.
    if (key_valid && key <= KEY_CLEAR) begin
      tmr_n = 8'd0;
      if (key <= 4'd9) begin
        if (state == IDLE) begin
          ms_hr_n  = 4'd0;
          ls_hr_n  = 4'd0;
          ms_min_n = 4'd0;
          ls_min_n = key;
          cnt_n    = 3'd1;
          state_n  = ENTRY;
        end else begin
          ms_hr_n  = key_buffer_ls_hr;
          ls_hr_n  = key_buffer_ms_min;
          ms_min_n = key_buffer_ls_min;
          ls_min_n = key;
          if (cnt >= 3'd3) begin
            cnt_n   = 3'd4;
            state_n = FULL;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end else if (key == KEY_ALARM || key == KEY_TIME) begin
        state_n = IDLE;
        cnt_n   = 3'd0;
        if (state == FULL && buf_valid) begin
          load_a_n = (key == KEY_ALARM);
          load_c_n = (key == KEY_TIME);
        end else begin
          error_n  = 1'b1;
          ms_hr_n  = 4'd0;
          ls_hr_n  = 4'd0;
          ms_min_n = 4'd0;
          ls_min_n = 4'd0;
        end
      end else begin
        state_n  = IDLE;
        cnt_n    = 3'd0;
        ms_hr_n  = 4'd0;
        ls_hr_n  = 4'd0;
        ms_min_n = 4'd0;
        ls_min_n = 4'd0;
      end
    end else if (one_second && state != IDLE) begin
      if (tmr == TMO_LAST) begin
        timeout_n = 1'b1;
        state_n   = IDLE;
        cnt_n     = 3'd0;
        tmr_n     = 8'd0;
        ms_hr_n   = 4'd0;
        ls_hr_n   = 4'd0;
        ms_min_n  = 4'd0;
        ls_min_n  = 4'd0;
      end else begin
        tmr_n = tmr + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= 3'd0;
      tmr               <= 8'd0;
      key_buffer_ms_hr  <= 4'd0;
      key_buffer_ls_hr  <= 4'd0;
      key_buffer_ms_min <= 4'd0;
      key_buffer_ls_min <= 4'd0;
      load_new_a        <= 1'b0;
      load_new_c        <= 1'b0;
      show_new_time     <= 1'b0;
      entry_error       <= 1'b0;
      entry_timeout     <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      tmr               <= tmr_n;
      key_buffer_ms_hr  <= ms_hr_n;
      key_buffer_ls_hr  <= ls_hr_n;
      key_buffer_ms_min <= ms_min_n;
      key_buffer_ls_min <= ls_min_n;
      load_new_a        <= load_a_n;
      load_new_c        <= load_c_n;
      show_new_time     <= (state_n != IDLE);
      entry_error       <= error_n;
      entry_timeout     <= timeout_n;
    end
  end

endmodule
